fi_mem_responder: RTL
=====================

// Module: fi_mem_responder
//
// PURPOSE
//  Bus-slave memory model that drives the imem/dmem response side of the core
//  memory interface: req/gnt request handshake, recv/ack response handshake.
//  Sits between the core and the fairness tracker; one instance per port.
//  Free stall inputs let a formal or random engine perturb timing. Built-in
//  stall bounds keep every trace inside the team's fairness limits.
//
// PARAMETERS
//  DEPTH          4         max outstanding accepted requests; power of 2, >=2
//  MEM_WORDS      1024      32-bit words of backing store; power of 2
//  BASE_ADDR      32'h0     byte address of word 0
//  MAX_GNT_STALL  2         max consecutive cycles req is held off by stall_gnt
//  MAX_RSP_STALL  2         max consecutive cycles a ready response is withheld
//
// PORTS
//  clock        in   1    clock
//  reset        in   1    reset, synchronous, active-high
//  mem_req      in   1    request valid; addr/wen/strb/wdata stable while req&&!gnt
//  mem_gnt      out  1    request accepted this cycle
//  mem_wen      in   1    1 = write, 0 = read
//  mem_strb     in   4    byte write strobes
//  mem_addr     in   32   byte address; bits [1:0] ignored
//  mem_wdata    in   32   write data
//  mem_recv     out  1    response valid
//  mem_ack      in   1    core accepts response
//  mem_error    out  1    response carries a bus error
//  mem_rdata    out  32   read data; 0 for writes
//  stall_gnt    in   1    stimulus: request to withhold gnt this cycle
//  stall_rsp    in   1    stimulus: request to withhold a new recv this cycle
//  outstanding  out  $clog2(DEPTH)+1  accepted but not yet acked requests
//
// BEHAVIOUR
//  - Reset: FIFO emptied, both stall counters 0, presenting=0. Outputs:
//    gnt=0, recv=0, error=0, rdata=0, outstanding=0. Backing store not reset.
//  - Reset mid-operation discards all queued entries; no response is given
//    for requests accepted before reset.
//  - gnt (combinational) = req && !full && !(stall_gnt && gstall<MAX_GNT_STALL).
//    full comes from registered count; a pop in the same cycle does not free
//    a slot until the next cycle.
//  - gstall: +1 on req&&!gnt, cleared on gnt or !req; saturates at MAX_GNT_STALL.
//  - On req&&gnt, memory is accessed in that cycle. Index = (addr-BASE_ADDR)>>2,
//    mod MEM_WORDS.
//    - Write: byte lanes with strb=1 are updated; the entry stores rdata=0.
//    - Read: the entry stores the pre-write word.
//    - Entry {rdata,error} is pushed to the FIFO.
//    - Ordering is program order: a read after a write sees the written data.
//  - Min latency is 1: an entry pushed in cycle N can first appear on recv in
//    cycle N+1.
//  - Response: when !presenting and !empty, recv is asserted unless
//    stall_rsp && rstall<MAX_RSP_STALL.
//    - rstall: +1 per withheld cycle, cleared when recv rises.
//    - Once recv=1 it stays 1 until ack (presenting=1).
//    - rdata/error are held stable from FIFO head until ack.
//  - recv&&ack pops the head. The next entry may be presented in the same
//    cycle (back-to-back), subject to the stall rule.
//  - ack without recv is ignored.
//  - outstanding = count; +1 on push, -1 on pop, unchanged on simultaneous
//    push and pop.
//
// CONFIGURATION
//  FI_MEM_ERROR_EN defined: a request whose address lies outside
//    [BASE_ADDR, BASE_ADDR+4*MEM_WORDS) is still granted, with no memory
//    access. Its response has error=1 and rdata=0.
//  Not defined: addresses wrap modulo MEM_WORDS and mem_error is tied 0.
//
// STRUCTURE
//  Package fi_mem_pkg:
//    - typedef fi_mem_rsp_t {logic [31:0] rdata; logic error;}
//    - localparams for byte-lane masks.
//  Sub-module fi_mem_fifo: synchronous DEPTH-entry FIFO of fi_mem_rsp_t with
//    push/pop/full/empty/count. Pointers wrap modulo DEPTH; count is 1 bit wider.
//  Top level holds the backing store, stall counters and presenting flag.
//
// TESTING
//  1. Write 0xDEADBEEF @0x10 (strb=F), then read @0x10 with no stalls
//     -> gnt same cycle; recv 1 cycle later; rdata=0xDEADBEEF, error=0.
//  2. strb=4'b0010 write 0xAAAAAAAA over 0xDEADBEEF, then read
//     -> rdata=0xDEADAABEF? no: 0xDEADAAEF.
//  3. stall_gnt=1 held with req=1 -> gnt withheld exactly 2 cycles,
//     forced high on the 3rd.
//  4. Hold ack=0 and issue 4 reads -> outstanding=4; 5th req sees gnt=0.
//     Ack once -> gnt returns the following cycle.
//  5. stall_rsp=1 toggled while recv=1 and ack=0 -> recv and rdata remain
//     stable until ack.
//  6. Reset asserted with 3 outstanding -> outstanding=0 and recv=0 next cycle.
//     With FI_MEM_ERROR_EN, a read @BASE+4*MEM_WORDS -> error=1, rdata=0.

Source files
------------

// File: rtl/fi_mem_pkg.sv
// Shared types for the memory responder: response entry layout and byte-lane masks.
package fi_mem_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
    } fi_mem_rsp_t;

    localparam logic [31:0] LANE0_MASK = 32'h0000_00FF;
    localparam logic [31:0] LANE1_MASK = 32'h0000_FF00;
    localparam logic [31:0] LANE2_MASK = 32'h00FF_0000;
    localparam logic [31:0] LANE3_MASK = 32'hFF00_0000;

    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        return ({32{strb[0]}} & LANE0_MASK) | ({32{strb[1]}} & LANE1_MASK) |
               ({32{strb[2]}} & LANE2_MASK) | ({32{strb[3]}} & LANE3_MASK);
    endfunction

endpackage

// File: rtl/fi_mem_if.sv
// Core memory port bundle: request channel (req/gnt) and response channel (recv/ack).
interface fi_mem_if;
    // A request transfers when req && gnt; addr/wen/strb/wdata hold while req && !gnt.
    // A response transfers when recv && ack; rdata/error hold while recv && !ack.
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_wen;
    logic [3:0]  mem_strb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_recv;
    logic        mem_ack;
    logic        mem_error;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_wen, mem_strb, mem_addr, mem_wdata, mem_ack,
        input  mem_gnt, mem_recv, mem_error, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wen, mem_strb, mem_addr, mem_wdata, mem_ack,
        output mem_gnt, mem_recv, mem_error, mem_rdata
    );
endinterface

// File: rtl/fi_mem_fifo.sv
// Synchronous response FIFO; pointers wrap modulo DEPTH, count is one bit wider.
module fi_mem_fifo
    import fi_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  fi_mem_rsp_t              wr_data,
    output fi_mem_rsp_t              rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    fi_mem_rsp_t           store_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [PW:0]           count_q;

    always_ff @(posedge clock) begin
        if (push) store_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data = store_q[rd_ptr_q];
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
endmodule

// File: rtl/fi_mem_responder.sv
// Bus-slave memory model with bounded gnt/recv stall injection.
// Optional FI_MEM_ERROR_EN: out-of-window addresses answer with error instead of wrapping.
module fi_mem_responder
    import fi_mem_pkg::*;
#(
    parameter int          DEPTH         = 4,
    parameter int          MEM_WORDS     = 1024,
    parameter logic [31:0] BASE_ADDR     = 32'h0,
    parameter int          MAX_GNT_STALL = 2,
    parameter int          MAX_RSP_STALL = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    fi_mem_if.slave                bus,
    input  logic                   stall_gnt,
    input  logic                   stall_rsp,
    output logic [$clog2(DEPTH):0] outstanding
);
    localparam int AW  = $clog2(MEM_WORDS);
    localparam int GSW = $clog2(MAX_GNT_STALL + 1) + 1;
    localparam int RSW = $clog2(MAX_RSP_STALL + 1) + 1;

    logic [31:0]    mem_q [MEM_WORDS];
    logic [GSW-1:0] gstall_q, gstall_d;
    logic [RSW-1:0] rstall_q, rstall_d;
    logic           presenting_q, presenting_d;

    logic [31:0]    offset;
    logic [AW-1:0]  idx;
    logic           in_range;
    logic           push, pop, full, empty, rsp_block, recv;
    fi_mem_rsp_t    push_rsp, head_rsp;

    assign offset = bus.mem_addr - BASE_ADDR;
    assign idx    = AW'(offset >> 2);
`ifdef FI_MEM_ERROR_EN
    assign in_range = ((offset >> 2) < 32'(MEM_WORDS));
`else
    assign in_range = 1'b1;
`endif

    assign bus.mem_gnt = bus.mem_req && !full &&
                         !(stall_gnt && (gstall_q < GSW'(MAX_GNT_STALL)));
    assign push = bus.mem_req && bus.mem_gnt;

    // Read-before-write: a read entry captures the stored word before any update this cycle.
    always_ff @(posedge clock) begin
        if (push && bus.mem_wen && in_range)
            mem_q[idx] <= (mem_q[idx] & ~strb_to_mask(bus.mem_strb)) |
                          (bus.mem_wdata & strb_to_mask(bus.mem_strb));
    end

    always_comb begin
        push_rsp.rdata = (bus.mem_wen || !in_range) ? 32'h0 : mem_q[idx];
        push_rsp.error = !in_range;
    end

    fi_mem_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (push_rsp),
        .rd_data (head_rsp),
        .full    (full),
        .empty   (empty),
        .count   (outstanding)
    );

    assign rsp_block = stall_rsp && (rstall_q < RSW'(MAX_RSP_STALL));
    assign recv      = presenting_q || (!empty && !rsp_block);
    assign pop       = recv && bus.mem_ack;

    always_comb begin
        gstall_d = gstall_q;
        if (!bus.mem_req || bus.mem_gnt)
            gstall_d = '0;
        else if (gstall_q < GSW'(MAX_GNT_STALL))
            gstall_d = gstall_q + 1'b1;

        rstall_d = rstall_q;
        if (recv && !presenting_q)
            rstall_d = '0;
        else if (!presenting_q && !empty && rsp_block)
            rstall_d = rstall_q + 1'b1;

        presenting_d = recv && !bus.mem_ack;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gstall_q     <= '0;
            rstall_q     <= '0;
            presenting_q <= 1'b0;
        end else begin
            gstall_q     <= gstall_d;
            rstall_q     <= rstall_d;
            presenting_q <= presenting_d;
        end
    end

    assign bus.mem_recv  = recv;
    assign bus.mem_rdata = recv ? head_rsp.rdata : 32'h0;
    assign bus.mem_error = recv ? head_rsp.error : 1'b0;
endmodule
